// File: rtl/uart_tx_arb.sv
// Two-source arbiter in front of a single UART transmitter.
// Requester 0 (CPU data-register writes) and requester 1 (debug/trace) each
// own a small FIFO. A round-robin scheduler pops one byte at a time and
// sequences the transmitter's start strobe / completion pulse handshake.
module uart_tx_arb #(
    parameter int DEPTH = 4,  // entries per requester FIFO, power of two
    parameter int AW    = 2   // log2(DEPTH)
) (
    input  logic       clock,
    input  logic       reset,       // asynchronous, active low
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_full,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_full,
    input  logic       ovf_clr,
    output logic [1:0] ovf,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    input  logic       tx_done,
    output logic       grant,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    // Scheduler state
    state_e        state_q, state_d;
    logic          launch;
    logic          winner;

    // Per-requester FIFO storage and bookkeeping, index = requester number
    logic [7:0]    mem_q    [2][DEPTH];
    logic [AW-1:0] wr_ptr_q [2];
    logic [AW-1:0] wr_ptr_d [2];
    logic [AW-1:0] rd_ptr_q [2];
    logic [AW-1:0] rd_ptr_d [2];
    logic [AW:0]   cnt_q    [2];
    logic [AW:0]   cnt_d    [2];
    logic [7:0]    push_data[2];
    logic [1:0]    push_v;
    logic [1:0]    not_empty;
    logic [1:0]    is_full;
    logic [1:0]    pop;
    logic [1:0]    push_ok;
    logic [1:0]    ovf_set;

    // Registered outputs
    logic          tx_dv_q,   tx_dv_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          grant_q,   grant_d;
    logic [1:0]    ovf_q,     ovf_d;

    assign push_v       = {req1_valid, req0_valid};
    assign push_data[0] = req0_data;
    assign push_data[1] = req1_data;

    // FIFO status flags, decoded from the registered counts only
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        not_empty = '0;
        is_full   = '0;
        for (int i = 0; i < 2; i++) begin
            not_empty[i] = (cnt_q[i] != '0);
            is_full[i]   = (cnt_q[i] == DEPTH_C);
        end
    end

    // Scheduler next state: pick a round-robin winner in IDLE and launch it
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        winner  = grant_q;
        pop     = '0;
        case (state_q)
            IDLE: begin
                if (|not_empty) begin
                    launch  = 1'b1;
                    // Both pending: alternate away from the last grant.
                    // One pending: that requester wins outright.
                    winner  = (&not_empty) ? ~grant_q : not_empty[1];
                    pop     = winner ? 2'b10 : 2'b01;
                    state_d = LAUNCH;
                end
            end
            LAUNCH:    state_d = WAIT_DONE;
            WAIT_DONE: if (tx_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // FIFO pointer/count update; a same-cycle pop frees the slot for a push
    always_comb begin
        push_ok = '0;
        ovf_set = '0;
        for (int i = 0; i < 2; i++) begin
            push_ok[i]  = push_v[i] & (~is_full[i] | pop[i]);
            ovf_set[i]  = push_v[i] & is_full[i] & ~pop[i];
            wr_ptr_d[i] = wr_ptr_q[i] + AW'(push_ok[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + AW'(pop[i]);
            cnt_d[i]    = cnt_q[i] + (AW + 1)'(push_ok[i]) - (AW + 1)'(pop[i]);
        end
    end

    // Output next state: capture the winner's head byte at launch and hold it
    always_comb begin
        tx_dv_d   = launch;
        tx_byte_d = tx_byte_q;
        grant_d   = grant_q;
        if (launch) begin
            tx_byte_d = mem_q[winner][rd_ptr_q[winner]];
            grant_d   = winner;
        end
        // A set in the same cycle as a clear wins.
        ovf_d = (ovf_q & ~{2{ovf_clr}}) | ovf_set;
    end

    // Control and status registers; reset discards all buffered bytes
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state_q   <= IDLE;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            grant_q   <= 1'b1;  // requester 0 wins the first contested round
            ovf_q     <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            state_q   <= state_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            grant_q   <= grant_d;
            ovf_q     <= ovf_d;
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    // FIFO storage writes
    always_ff @(posedge clock) begin
        // NOTE: the storage array has no reset; the counts alone decide which entries are live.
        for (int i = 0; i < 2; i++) begin
            if (push_ok[i]) begin
                mem_q[i][wr_ptr_q[i]] <= push_data[i];
            end
        end
    end

    assign req0_full = is_full[0];
    assign req1_full = is_full[1];
    assign ovf       = ovf_q;
    assign tx_dv     = tx_dv_q;
    assign tx_byte   = tx_byte_q;
    assign grant     = grant_q;
    assign busy      = (state_q != IDLE) | (|not_empty);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: a queue-based reference model predicts
// every launch into a scoreboard; a monitor on the falling edge pops and
// compares whenever the DUT strobes tx_dv, and checks status flags each cycle.
module tb_uart_tx_arb;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data  = 8'h00;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data  = 8'h00;
    logic       ovf_clr    = 1'b0;
    logic       man_done   = 1'b0;
    logic       auto_pulse = 1'b0;
    logic       tx_done;
    logic       req0_full, req1_full, tx_dv, grant, busy;
    logic [1:0] ovf;
    logic [7:0] tx_byte;

    assign tx_done = man_done | auto_pulse;

    always #5 clock = ~clock;

    uart_tx_arb #(.DEPTH(DEPTH), .AW(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_full  (req0_full),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_full  (req1_full),
        .ovf_clr    (ovf_clr),
        .ovf        (ovf),
        .tx_dv      (tx_dv),
        .tx_byte    (tx_byte),
        .tx_done    (tx_done),
        .grant      (grant),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each requester is a plain byte queue. A transfer is "in flight" from
    // the launch decision until a done pulse arrives after the strobe cycle.
    logic [7:0] mq0[$];
    logic [7:0] mq1[$];
    logic [8:0] exp_q[$];       // {grant, byte} of predicted launches
    logic [8:0] launch_log[$];  // {grant, byte} of observed launches
    bit         m_idle   = 1'b1;
    bit         m_strobe = 1'b0;
    bit         m_grant  = 1'b1;
    logic [1:0] m_ovf    = 2'b00;
    bit         m_w;
    logic [7:0] m_b;
    logic [1:0] m_set;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq0.delete();
            mq1.delete();
            exp_q.delete();
            m_idle   = 1'b1;
            m_strobe = 1'b0;
            m_grant  = 1'b1;
            m_ovf    = 2'b00;
        end else begin
            if (m_idle) begin
                if (mq0.size() != 0 || mq1.size() != 0) begin
                    if (mq0.size() != 0 && mq1.size() != 0) m_w = ~m_grant;
                    else m_w = (mq0.size() == 0);
                    m_b = m_w ? mq1.pop_front() : mq0.pop_front();
                    exp_q.push_back({m_w, m_b});
                    m_grant  = m_w;
                    m_idle   = 1'b0;
                    m_strobe = 1'b1;
                end
            end else if (m_strobe) begin
                m_strobe = 1'b0;
            end else if (tx_done) begin
                m_idle = 1'b1;
            end
            // Pops happened above, so a full queue being popped has room now.
            m_set = 2'b00;
            if (req0_valid) begin
                if (mq0.size() < DEPTH) mq0.push_back(req0_data);
                else m_set[0] = 1'b1;
            end
            if (req1_valid) begin
                if (mq1.size() < DEPTH) mq1.push_back(req1_data);
                else m_set[1] = 1'b1;
            end
            if (ovf_clr) m_ovf = 2'b00;
            m_ovf = m_ovf | m_set;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [8:0] mon_e;
    always @(negedge clock) begin
        if (reset) begin
            check("tx_dv_timing", 32'(tx_dv), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                if (tx_dv) begin
                    check("tx_byte", 32'(tx_byte), 32'(mon_e[7:0]));
                    check("grant", 32'(grant), 32'(mon_e[8]));
                    launch_log.push_back({grant, tx_byte});
                end
            end
            check("req0_full", 32'(req0_full), 32'(mq0.size() == DEPTH));
            check("req1_full", 32'(req1_full), 32'(mq1.size() == DEPTH));
            check("ovf", 32'(ovf), 32'(m_ovf));
            check("busy", 32'(busy), 32'(!m_idle || mq0.size() != 0 || mq1.size() != 0));
        end
    end

    // ---------------- transmitter responder ----------------
    bit auto_done  = 1'b0;
    int done_delay = 0;   // 0 selects a random delay
    initial begin
        int d;
        forever begin
            @(negedge clock);
            if (auto_done && tx_dv && reset) begin
                d = (done_delay != 0) ? done_delay : int'($urandom_range(1, 12));
                repeat (d) @(posedge clock);
                #1 auto_pulse = 1'b1;
                @(posedge clock);
                #1 auto_pulse = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        auto_done  = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        ovf_clr    = 1'b0;
        man_done   = 1'b0;
        reset      = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        launch_log.delete();
    endtask

    task automatic pulse_done();
        man_done = 1'b1;
        step();
        man_done = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(n < 2000), 32'(1));
        step();
    endtask

    task automatic check_log(input string name, input logic [8:0] exp[$]);
        check({name, "_count"}, 32'(launch_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < launch_log.size(); i++) begin
            check($sformatf("%s_%0d", name, i), 32'(launch_log[i]), 32'(exp[i]));
        end
    endtask

    // ---------------- directed and random tests ----------------
    initial begin
        logic [8:0] exp_log[$];

        // Reset state and single-byte latency
        do_reset();
        @(negedge clock);
        check("rst_tx_dv", 32'(tx_dv), 0);
        check("rst_tx_byte", 32'(tx_byte), 0);
        check("rst_grant", 32'(grant), 1);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_full", 32'({req1_full, req0_full}), 0);
        check("rst_busy", 32'(busy), 0);
        step();
        req0_valid = 1'b1;
        req0_data  = 8'h41;
        step();
        req0_valid = 1'b0;
        @(negedge clock);
        check("single_k1_dv", 32'(tx_dv), 0);
        @(negedge clock);
        check("single_k2_dv", 32'(tx_dv), 1);
        check("single_byte", 32'(tx_byte), 32'h41);
        check("single_grant", 32'(grant), 0);
        @(negedge clock);
        check("single_k3_dv", 32'(tx_dv), 0);
        check("single_hold", 32'(tx_byte), 32'h41);
        repeat (8) step();
        check("single_busy_wait", 32'(busy), 1);
        pulse_done();
        @(negedge clock);
        check("single_busy_end", 32'(busy), 0);

        // Round-robin between both requesters
        do_reset();
        auto_done  = 1'b1;
        done_delay = 10;
        step();
        req0_valid = 1'b1; req0_data = 8'h10;
        req1_valid = 1'b1; req1_data = 8'hA0;
        step();
        req0_data = 8'h11;
        req1_data = 8'hA1;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle("rr_drain");
        exp_log.delete();
        exp_log.push_back({1'b0, 8'h10});
        exp_log.push_back({1'b1, 8'hA0});
        exp_log.push_back({1'b0, 8'h11});
        exp_log.push_back({1'b1, 8'hA1});
        check_log("rr_order", exp_log);

        // Overflow on requester 1 with done withheld
        do_reset();
        done_delay = 0;
        step();
        for (int i = 1; i <= 6; i++) begin
            req1_valid = 1'b1;
            req1_data  = 8'(i);
            step();
        end
        req1_valid = 1'b0;
        @(negedge clock);
        check("ovf_full1", 32'(req1_full), 1);
        check("ovf_flag", 32'(ovf), 32'b10);
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        @(negedge clock);
        check("ovf_cleared", 32'(ovf), 0);
        step();
        pulse_done();
        auto_done = 1'b1;
        wait_idle("ovf_drain");
        exp_log.delete();
        for (int i = 1; i <= 5; i++) exp_log.push_back({1'b1, 8'(i)});
        check_log("ovf_order", exp_log);

        // Push into a full FIFO in the same cycle it is popped
        do_reset();
        step();
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1'b1;
            req0_data  = 8'(8'h20 + i);
            step();
        end
        req0_valid = 1'b0;
        @(negedge clock);
        check("pp_full_before", 32'(req0_full), 1);
        step();
        man_done = 1'b1;
        step();
        man_done   = 1'b0;
        auto_done  = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 8'h55;
        step();
        req0_valid = 1'b0;
        @(negedge clock);
        check("pp_no_ovf", 32'(ovf), 0);
        check("pp_full_after", 32'(req0_full), 1);
        wait_idle("pp_drain");
        exp_log.delete();
        for (int i = 0; i < 5; i++) exp_log.push_back({1'b0, 8'(8'h20 + i)});
        exp_log.push_back({1'b0, 8'h55});
        check_log("pp_order", exp_log);

        // Reset in the middle of a transfer
        do_reset();
        step();
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1;
            req0_data  = 8'(8'h30 + i);
            step();
        end
        req0_valid = 1'b0;
        repeat (3) step();
        check("mid_busy_before", 32'(busy), 1);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_dv", 32'(tx_dv), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_full", 32'({req1_full, req0_full}), 0);
        @(posedge clock);
        #2 reset = 1'b1;
        step();
        pulse_done();
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("mid_after_dv", 32'(tx_dv), 0);
        end
        check("mid_after_busy", 32'(busy), 0);

        // Spurious done while idle and empty
        step();
        pulse_done();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("spur_dv", 32'(tx_dv), 0);
            check("spur_busy", 32'(busy), 0);
        end

        // Randomised traffic with bursty density to exercise overflow
        do_reset();
        auto_done  = 1'b1;
        done_delay = 0;
        for (int c = 0; c < 3000; c++) begin
            int dens;
            dens       = ((c / 200) % 2 == 0) ? 10 : 60;
            req0_valid = ($urandom_range(0, 99) < dens);
            req0_data  = 8'($urandom);
            req1_valid = ($urandom_range(0, 99) < dens);
            req1_data  = 8'($urandom);
            ovf_clr    = ($urandom_range(0, 63) == 0);
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        ovf_clr    = 1'b0;
        wait_idle("rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
